// File: rtl/sdrc_pkg.sv
// Shared SDRAM-controller definitions: transfer-counter FSM encoding and default widths.
package sdrc_pkg;

  localparam int unsigned SDRC_LEN_W = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } xfr_state_e;

endpackage : sdrc_pkg

// File: rtl/sdrc_dec.sv
// Combinational decrement-by-one (DIFF = A - 1 modulo 2^LEN_W) built as a ripple borrow chain.
module sdrc_dec
  import sdrc_pkg::*;
#(
  parameter int unsigned LEN_W = SDRC_LEN_W
) (
  input  logic [LEN_W-1:0] a,
  output logic [LEN_W-1:0] diff
);

  logic w_borrow;

  always_comb begin
    diff     = '0;
    w_borrow = 1'b1;
    for (int i = 0; i < int'(LEN_W); i++) begin
      diff[i]  = a[i] ^ w_borrow;
      w_borrow = w_borrow & ~a[i];
    end
  end

endmodule : sdrc_dec

// File: rtl/sdrc_xfr_dnctr.sv
// Transfer down-counter: loads a beat count, counts beats down to a one-cycle done pulse,
// supports abort, and flags stray beats seen outside a transfer.
module sdrc_xfr_dnctr
  import sdrc_pkg::*;
#(
  parameter int unsigned LEN_W = SDRC_LEN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld_valid,
  input  logic [LEN_W-1:0] ld_len,
  output logic             ld_ready,
  input  logic             beat,
  input  logic             abort,
  output logic [LEN_W-1:0] cnt,
  output logic             busy,
  output logic             last,
  output logic             done,
  output logic             err
);

  localparam logic [LEN_W-1:0] LP_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LP_TWO = LEN_W'(2);

  xfr_state_e       r_state;
  logic [LEN_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_last;
  logic             r_done;
  logic             r_err;
  logic [LEN_W-1:0] w_dec;

  sdrc_dec #(.LEN_W(LEN_W)) u_dec (
    .a    (r_cnt),
    .diff (w_dec)
  );

  // State, count and flags; last is precomputed so it is high exactly while RUN holds cnt=1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ld_valid) begin
            r_err <= beat;
            if (ld_len != '0) begin
              r_state <= ST_RUN;
              r_cnt   <= ld_len;
              r_busy  <= 1'b1;
              r_last  <= (ld_len == LP_ONE);
            end else begin
              r_state <= ST_DONE;
              r_cnt   <= '0;
              r_done  <= 1'b1;
            end
          end else if (beat) begin
            r_err <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
          end else if (beat && (r_cnt != '0)) begin
            r_cnt  <= w_dec;
            r_last <= (r_cnt == LP_TWO);
            if (r_cnt == LP_ONE) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          if (beat) r_err <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ld_ready = (r_state == ST_IDLE);
  assign cnt      = r_cnt;
  assign busy     = r_busy;
  assign last     = r_last;
  assign done     = r_done;
  assign err      = r_err;

endmodule : sdrc_xfr_dnctr

// File: tb/tb_sdrc_xfr_dnctr.sv
// Self-checking bench for sdrc_xfr_dnctr: directed scenarios plus randomized traffic
// compared every cycle against an integer transfer model.
module tb_sdrc_xfr_dnctr;

  localparam int unsigned LEN_W = 13;
  localparam int          MAXLEN = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             ld_valid;
  logic [LEN_W-1:0] ld_len;
  logic             ld_ready;
  logic             beat;
  logic             abort;
  logic [LEN_W-1:0] cnt;
  logic             busy;
  logic             last;
  logic             done;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done_seen = 0;

  // Reference model: remaining beats plus "in transfer" / "completing" flags.
  int m_rem;
  bit m_xfer;
  bit m_fin;
  bit m_err;

  sdrc_xfr_dnctr #(.LEN_W(LEN_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ld_valid (ld_valid),
    .ld_len   (ld_len),
    .ld_ready (ld_ready),
    .beat     (beat),
    .abort    (abort),
    .cnt      (cnt),
    .busy     (busy),
    .last     (last),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation time budget exhausted");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_xfer = 0; m_fin = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input int len, input bit b, input bit a);
    if (m_fin) begin
      m_fin = 0;
      if (b) m_err = 1;
    end else if (m_xfer) begin
      if (a) begin
        m_xfer = 0; m_rem = 0;
      end else if (b) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin m_xfer = 0; m_fin = 1; end
      end
    end else if (v) begin
      m_err = b;
      m_rem = len;
      if (len == 0) m_fin = 1; else m_xfer = 1;
    end else if (b) begin
      m_err = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".cnt"},      int'(cnt),      m_rem);
    check_eq({tag, ".busy"},     int'(busy),     int'(m_xfer));
    check_eq({tag, ".done"},     int'(done),     int'(m_fin));
    check_eq({tag, ".err"},      int'(err),      int'(m_err));
    check_eq({tag, ".last"},     int'(last),     int'(m_xfer && m_rem == 1));
    check_eq({tag, ".ld_ready"}, int'(ld_ready), int'(!m_xfer && !m_fin));
  endtask

  // One clock: drive inputs, model the edge, check #1 after it.
  task automatic cycle(input string tag, input bit v, input int len, input bit b, input bit a);
    ld_valid = v; ld_len = LEN_W'(len); beat = b; abort = a;
    @(posedge clk);
    model_step(v, len, b, a);
    #1;
    if (done) n_done_seen++;
    check_all(tag);
  endtask

  initial begin
    int exp_dones;
    reset_n = 1'b0; ld_valid = 0; ld_len = '0; beat = 0; abort = 0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    check_all("reset_hold");
    reset_n = 1'b1;

    // Length 4 with continuous beats.
    cycle("l4_load", 1, 4, 0, 0);
    check_eq("l4_cnt_after_load", int'(cnt), 4);
    for (int i = 0; i < 4; i++) cycle("l4_beat", 0, 0, 1, 0);
    check_eq("l4_done_pulse", int'(done), 1);
    cycle("l4_after", 0, 0, 0, 0);
    check_eq("l4_ready_back", int'(ld_ready), 1);

    // Zero-length load completes immediately.
    cycle("l0_load", 1, 0, 0, 0);
    check_eq("l0_done", int'(done), 1);
    check_eq("l0_busy", int'(busy), 0);
    cycle("l0_after", 0, 0, 0, 0);

    // Abort with a coincident beat after 2 of 5 beats.
    cycle("ab_load", 1, 5, 0, 0);
    cycle("ab_b1", 0, 0, 1, 0);
    cycle("ab_b2", 0, 0, 1, 0);
    check_eq("ab_cnt3", int'(cnt), 3);
    cycle("ab_abort", 0, 0, 1, 1);
    check_eq("ab_cnt0", int'(cnt), 0);
    check_eq("ab_ready", int'(ld_ready), 1);
    cycle("ab_nodone", 0, 0, 0, 0);
    check_eq("ab_nodone_chk", int'(done), 0);

    // Stray beat in IDLE sets sticky err; next load clears it.
    cycle("err_beat", 0, 0, 1, 0);
    check_eq("err_set", int'(err), 1);
    cycle("err_hold1", 0, 0, 0, 1);
    cycle("err_hold2", 0, 0, 0, 0);
    check_eq("err_sticky", int'(err), 1);
    cycle("err_load", 1, 2, 0, 0);
    check_eq("err_cleared", int'(err), 0);
    cycle("err_b1", 0, 0, 1, 0);
    cycle("err_b2", 0, 0, 1, 0);
    cycle("err_done_beat", 0, 0, 1, 0);
    check_eq("err_beat_in_done", int'(err), 1);
    cycle("err_ld_beat", 1, 1, 1, 0);
    check_eq("err_load_with_beat", int'(err), 1);
    cycle("err_b", 0, 0, 1, 0);
    cycle("err_idle", 0, 0, 0, 0);

    // Async reset mid-RUN at cnt=3.
    cycle("ar_load", 1, 5, 0, 0);
    cycle("ar_b1", 0, 0, 1, 0);
    cycle("ar_b2", 0, 0, 1, 0);
    check_eq("ar_cnt3", int'(cnt), 3);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("ar_async");
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_all("ar_held");
    for (int i = 0; i < 4; i++) cycle("ar_after", 0, 0, 0, 0);
    cycle("ar_first_load", 1, 1, 0, 0);
    cycle("ar_first_beat", 0, 0, 1, 0);
    cycle("ar_idle", 0, 0, 0, 0);

    // Maximum length with beats on every other cycle.
    exp_dones = n_done_seen + 1;
    cycle("max_load", 1, MAXLEN, 0, 0);
    check_eq("max_cnt", int'(cnt), MAXLEN);
    for (int i = 0; i < 2 * MAXLEN; i++) cycle("max_run", 0, 0, (i % 2) == 0, 0);
    cycle("max_tail", 0, 0, 0, 0);
    check_eq("max_done_count", n_done_seen, exp_dones);
    check_eq("max_err", int'(err), 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit v, b, a;
      int len;
      v   = ($urandom_range(0, 3) == 0);
      len = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, MAXLEN)) : int'($urandom_range(0, 6));
      b   = ($urandom_range(0, 9) < 6);
      a   = ($urandom_range(0, 19) == 0);
      cycle("rand", v, len, b, a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sdrc_xfr_dnctr

// File: doc/sdrc_xfr_dnctr.md
SDRC_XFR_DNCTR -- requirements
Module: sdrc_xfr_dnctr

Interface
REQ-001 The block SHALL have parameter LEN_W, default 13, giving the transfer-length width in beats.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port ld_valid, input, 1 bit: a load request is present.
REQ-005 The block SHALL have port ld_len, input, LEN_W bits: transfer length in beats, sampled when a load is accepted.
REQ-006 The block SHALL have port ld_ready, output, 1 bit: a load is accepted this cycle if ld_valid is also high.
REQ-007 The block SHALL have port beat, input, 1 bit: one data beat was transferred this cycle.
REQ-008 The block SHALL have port abort, input, 1 bit: terminate the current transfer.
REQ-009 The block SHALL have port cnt, output, LEN_W bits: remaining beats.
REQ-010 The block SHALL have port busy, output, 1 bit: a transfer is in progress.
REQ-011 The block SHALL have port last, output, 1 bit: the next beat is the final beat.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port err, output, 1 bit: sticky flag for a beat outside a transfer.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 ld_ready SHALL equal 1 in IDLE and 0 in RUN and DONE; ld_ready is combinational from state only.
REQ-016 In IDLE, when ld_valid=1 and ld_len!=0, the next state SHALL be RUN and cnt SHALL load ld_len.
- cnt and busy are valid on the cycle after the accepting edge.
REQ-017 In IDLE, when ld_valid=1 and ld_len=0, the load SHALL be accepted and the next state SHALL be DONE with cnt=0.
REQ-018 In RUN, each cycle with beat=1 and abort=0 SHALL decrement cnt by exactly 1.
REQ-019 In RUN, when cnt=1 and beat=1, the next state SHALL be DONE and cnt SHALL become 0.
- cnt never wraps below 0.
REQ-020 In RUN, abort=1 SHALL force the next state to IDLE with cnt=0 and no done pulse.
- abort takes priority over a simultaneous beat.
REQ-021 abort SHALL be ignored in IDLE and DONE.
REQ-022 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-023 done SHALL be 1 only in DONE.
REQ-024 busy SHALL be 1 only in RUN.
REQ-025 last SHALL equal 1 exactly when state=RUN and cnt=1.
REQ-026 A beat in IDLE or DONE SHALL set err to 1.
- err stays at 1 until reset or until the next accepted load.
- If a beat and an accepted load coincide, err is set.
REQ-027 The maximum length SHALL be 2^LEN_W-1, which is 8191 at the default width.
REQ-028 cnt, busy, done and err SHALL be registered.
REQ-029 The decrement SHALL be computed modulo 2^LEN_W, and the result is used only when cnt!=0.

Reset
REQ-030 reset_n=0 SHALL immediately force state=IDLE, cnt=0, busy=0, done=0 and err=0, regardless of clk.
- last=0 and ld_ready=1 follow from this state.
REQ-031 Reset asserted mid-transfer SHALL discard the transfer without a done pulse.
REQ-032 The first accepted load after reset release SHALL be the first rising edge with ld_valid=1.

Structure
REQ-033 The FSM state encoding (IDLE, RUN, DONE) and the LEN_W default SHALL live in the shared sdrc package.
REQ-034 The decrement SHALL be implemented in one combinational sub-module, sdrc_dec.
- sdrc_dec is LEN_W wide and built from a borrow chain.
- Its interface is A in, DIFF out, with DIFF = A-1.
REQ-035 All other logic SHALL be in sdrc_xfr_dnctr.

Verification
REQ-036 Load ld_len=4, then assert beat continuously -> cnt shows 4,3,2,1; last is high while cnt=1; done pulses on the cycle after the fourth beat; ld_ready then returns to 1.
REQ-037 Load ld_len=0 -> done pulses on the next cycle; busy stays 0 throughout; cnt=0.
REQ-038 Load 8191 with beat gated every other cycle -> cnt decrements only on beat cycles; done follows after 8191 beats; err stays 0.
REQ-039 Load 5, give 2 beats, then assert abort and beat in the same cycle -> state IDLE, cnt=0, no done pulse, ld_ready=1.
REQ-040 Assert beat in IDLE -> err=1 and stays high; the next accepted load clears err.
REQ-041 Drop reset_n asynchronously mid-RUN with cnt=3 -> outputs reach reset values without a clock edge; no done pulse follows.
